inst_assembler: RTL and testbench
=================================

INST_ASSEMBLER -- requirements
Module: inst_assembler

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, the instruction-memory word address width.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1, a one-cycle pulse that begins a load run.
REQ-005 SHALL have port base_addr, input, ADDR_W, the first word address of the run, sampled on start.
REQ-006 SHALL have port count, input, ADDR_W, the number of beats in the run, sampled on start.
REQ-007 SHALL have port in_valid, input, 1, qualifying the field beat.
REQ-008 SHALL have port in_ready, output, 1, meaning a beat is accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port fmt, input, 3, the format code: R=0, I=1, S=2, B=3, U=4, J=5; codes 6 and 7 are illegal.
REQ-010 SHALL have ports opcode (7), rd/rs1/rs2 (5 each), funct3 (3), funct7 (7), imm32 (32), all inputs and all beat fields.
REQ-011 SHALL have ports wr_en (output, 1), wr_addr (output, ADDR_W) and wr_data (output, 32), the instruction-memory write port; the memory always accepts writes.
REQ-012 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse), err (output, 1, sticky) and err_cnt (output, 8).

Function
REQ-013 SHALL implement FSM IDLE -> RUN on start; RUN -> DONE when the accepted-beat count equals count; DONE -> IDLE after one cycle.
REQ-014 SHALL go from start with count=0 through RUN straight to DONE, with no beat accepted.
REQ-015 SHALL ignore start while in RUN or DONE.
REQ-016 SHALL drive in_ready high only in RUN while accepted beats < count.
REQ-017 SHALL drive busy high in RUN and DONE, and done high only in DONE.
REQ-018 SHALL, for a beat accepted in cycle N, assert wr_en in cycle N+1 with registered wr_addr and wr_data; one register stage gives latency 1 and throughput of one beat per cycle.
REQ-019 SHALL encode R format as {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-020 SHALL encode I format as {imm[11:0], rs1, funct3, rd, opcode}.
REQ-021 SHALL encode S format as {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-022 SHALL encode B format as {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-023 SHALL encode U format as {imm[31:12], rd, opcode}.
REQ-024 SHALL encode J format as {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-025 SHALL apply these imm32 range checks, with imm32 signed:
  - I/S: -2048..2047.
  - B: -4096..4094 and even.
  - J: -1048576..1048574 and even.
  - U: imm[11:0]=0.
  - R: none.
REQ-026 SHALL treat an illegal fmt or a failed range check as an error beat: still accepted and counted toward count, wr_en not asserted, write address not advanced, err set, err_cnt incremented.
REQ-027 SHALL saturate err_cnt at 255.
REQ-028 SHALL clear err and err_cnt only on rst or on the start that begins a new run.
REQ-029 SHALL load the write address from base_addr on start, increment it by 1 per good write, and wrap modulo 2^ADDR_W without flagging.
REQ-030 SHALL reach DONE in the cycle after the final write is issued.

Reset
REQ-031 SHALL, on rst, clear these to 0 regardless of state, including mid-run: state=IDLE, in_ready, wr_en, wr_addr, wr_data, busy, done, err, err_cnt and the beat counter.
REQ-032 SHALL not issue a write in the cycle after rst for a beat pending at reset.

Structure
REQ-033 SHALL place the fmt codes, the opcode constants and the immediate range limits in a shared package, inst_pkg.
REQ-034 SHALL use one combinational sub-module, inst_pack, for field packing plus range checking; the FSM, counters and output register stay in inst_assembler.

Verification
REQ-035 SHALL cover: base 0x10, count 1, I, opcode 0x13, rd=1, rs1=0, funct3=0, imm=5 -> wr_en at N+1, addr 0x10, data 0x00500093, done next cycle.
REQ-036 SHALL cover: S, opcode 0x23, rs1=1, rs2=2, funct3=2, imm=8 -> data 0x0020A423; B, opcode 0x63, rs1=0, rs2=0, funct3=0, imm=-4 -> data 0xFE000EE3.
REQ-037 SHALL cover: J, opcode 0x6F, rd=1, imm=2048 -> data 0x001000EF; back-to-back beats write consecutive addresses every cycle.
REQ-038 SHALL cover: count 3 with middle beat I imm=2048 -> two writes at base and base+1, err=1, err_cnt=1, done after the third beat.
REQ-039 SHALL cover: rst asserted mid-run after 2 of 5 beats -> all outputs 0 next cycle; a later start of count 1 runs normally.
REQ-040 SHALL cover: count=0 start -> no wr_en, done pulse two cycles after start; start during RUN -> no effect.

Source files
------------

// File: rtl/inst_pkg.sv
// Shared definitions for the instruction assembler: format codes, opcode
// constants, immediate range limits and the run-control state encoding.
package inst_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    // Signed immediate limits; B and J offsets must additionally be even.
    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMM13_MIN = -4096;
    localparam int IMM13_MAX = 4094;
    localparam int IMM21_MIN = -1048576;
    localparam int IMM21_MAX = 1048574;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/inst_pack.sv
// Combinational field packer: builds the 32-bit instruction word for the
// selected format and flags whether fmt and imm32 form a legal beat.
module inst_pack
    import inst_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm32,
    output logic [31:0] word,
    output logic        ok
);

    logic signed [31:0] imm_s;
    logic               in12;
    logic               in13;
    logic               in21;

    assign imm_s = imm32;
    assign in12  = (imm_s >= IMM12_MIN) && (imm_s <= IMM12_MAX);
    assign in13  = (imm_s >= IMM13_MIN) && (imm_s <= IMM13_MAX) && !imm32[0];
    assign in21  = (imm_s >= IMM21_MIN) && (imm_s <= IMM21_MAX) && !imm32[0];

    always_comb begin
        word = '0;
        ok   = 1'b0;
        case (fmt)
            FMT_R: begin
                word = {funct7, rs2, rs1, funct3, rd, opcode};
                ok   = 1'b1;
            end
            FMT_I: begin
                word = {imm32[11:0], rs1, funct3, rd, opcode};
                ok   = in12;
            end
            FMT_S: begin
                word = {imm32[11:5], rs2, rs1, funct3, imm32[4:0], opcode};
                ok   = in12;
            end
            FMT_B: begin
                word = {imm32[12], imm32[10:5], rs2, rs1, funct3,
                        imm32[4:1], imm32[11], opcode};
                ok   = in13;
            end
            FMT_U: begin
                word = {imm32[31:12], rd, opcode};
                ok   = (imm32[11:0] == 12'd0);
            end
            FMT_J: begin
                word = {imm32[20], imm32[10:1], imm32[11], imm32[19:12], rd, opcode};
                ok   = in21;
            end
            default: begin
                word = '0;
                ok   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/inst_assembler.sv
// Instruction assembler: accepts a counted run of field beats, packs each into
// an instruction word and writes good words to consecutive memory addresses.
module inst_assembler
    import inst_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm32,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        err_cnt
);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] beats_q;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;
    logic [7:0]        err_cnt_q;

    logic [31:0]       word_p0;
    logic              ok_p0;
    logic              vld_p0;
    logic              good_p0;

    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [31:0]       data_p1;

    inst_pack u_pack (
        .fmt    (fmt),
        .opcode (opcode),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .funct3 (funct3),
        .funct7 (funct7),
        .imm32  (imm32),
        .word   (word_p0),
        .ok     (ok_p0)
    );

    assign in_ready = (state_q == ST_RUN) && (beats_q < count_q);
    assign vld_p0   = in_valid && in_ready;
    assign good_p0  = vld_p0 && ok_p0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (beats_q == count_q) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            beats_q   <= '0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start) begin
                count_q   <= count;
                beats_q   <= '0;
                addr_q    <= base_addr;
                err_q     <= 1'b0;
                err_cnt_q <= '0;
            end else if (vld_p0) begin
                beats_q <= beats_q + 1'b1;
                if (ok_p0) begin
                    addr_q <= addr_q + 1'b1;
                end else begin
                    err_q     <= 1'b1;
                    err_cnt_q <= sat_inc8(err_cnt_q);
                end
            end
        end
    end

    // p0 -> p1: register the packed word and its address for the memory write
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= good_p0;
            if (good_p0) begin
                addr_p1 <= addr_q;
                data_p1 <= word_p0;
            end
        end
    end

    assign wr_en   = vld_p1;
    assign wr_addr = addr_p1;
    assign wr_data = data_p1;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_inst_assembler.sv
// Self-checking bench for inst_assembler: spec vectors, boundary immediates,
// randomized runs against an arithmetic reference model, and reset corners.
module tb_inst_assembler;

    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              rst, start, in_valid, in_ready;
    logic [ADDR_W-1:0] base_addr, count;
    logic [2:0]        fmt, funct3;
    logic [6:0]        opcode, funct7;
    logic [4:0]        rd, rs1, rs2;
    logic [31:0]       imm32;
    logic              wr_en, busy, done, err;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [7:0]        err_cnt;

    inst_assembler #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
        .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
        .imm32(imm32), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        bit          has_exp;
        bit          exp_ok;
        logic [31:0] exp_data;
    } beat_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        int                cyc;
    } wr_t;

    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    wr_t   expq[$];
    beat_t runq[$];
    beat_t tbl[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Write-port scoreboard: every write must match the next expected one,
    // including the cycle in which it appears.
    always @(negedge clk) begin
        if (wr_en) begin
            tests++;
            if (expq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", wr_addr, wr_data);
            end else begin
                wr_t e;
                e = expq.pop_front();
                if (wr_addr !== e.addr || wr_data !== e.data || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL write: got addr 0x%0h data 0x%0h cyc %0d, expected addr 0x%0h data 0x%0h cyc %0d",
                             wr_addr, wr_data, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    // Reference encoder built from shifts and masks of the field values.
    function automatic logic [31:0] ref_word(input beat_t b);
        logic [31:0] op, rdv, r1, r2, f3, f7, im;
        op = 32'(b.op); rdv = 32'(b.rd) << 7; r1 = 32'(b.rs1) << 15;
        r2 = 32'(b.rs2) << 20; f3 = 32'(b.f3) << 12; f7 = 32'(b.f7) << 25;
        im = b.imm;
        case (b.fmt)
            3'd0: return f7 | r2 | r1 | f3 | rdv | op;
            3'd1: return ((im & 32'hFFF) << 20) | r1 | f3 | rdv | op;
            3'd2: return (((im >> 5) & 32'h7F) << 25) | r2 | r1 | f3 | ((im & 32'h1F) << 7) | op;
            3'd3: return (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | r2 | r1 | f3
                         | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | op;
            3'd4: return (im & 32'hFFFFF000) | rdv | op;
            3'd5: return (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                         | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | rdv | op;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit ref_ok(input beat_t b);
        int s;
        s = int'(b.imm);
        case (b.fmt)
            3'd0: return 1'b1;
            3'd1, 3'd2: return (s >= -2048 && s <= 2047);
            3'd3: return (s >= -4096 && s <= 4094 && (s % 2 == 0));
            3'd4: return (b.imm % 4096 == 0);
            3'd5: return (s >= -1048576 && s <= 1048574 && (s % 2 == 0));
            default: return 1'b0;
        endcase
    endfunction

    function automatic beat_t mk(input int f, input int op, input int d, input int r1, input int r2,
                                 input int f3, input int f7, input int imm, input bit ok,
                                 input logic [31:0] data);
        beat_t b;
        b.fmt = 3'(f); b.op = 7'(op); b.rd = 5'(d); b.rs1 = 5'(r1); b.rs2 = 5'(r2);
        b.f3 = 3'(f3); b.f7 = 7'(f7); b.imm = 32'(imm);
        b.has_exp = 1'b1; b.exp_ok = ok; b.exp_data = data;
        return b;
    endfunction

    function automatic beat_t rnd_beat(input bit legal_only);
        beat_t b;
        int    edges[8] = '{2047, -2048, 2048, -2049, 4094, -4096, 1048574, -1048576};
        for (int tries = 0; tries < 100; tries++) begin
            b.fmt = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
            b.op = 7'($urandom); b.rd = 5'($urandom); b.rs1 = 5'($urandom);
            b.rs2 = 5'($urandom); b.f3 = 3'($urandom); b.f7 = 7'($urandom);
            case ($urandom_range(0, 3))
                0: b.imm = $urandom;
                1: b.imm = 32'(int'($urandom_range(0, 12000)) - 6000);
                2: b.imm = 32'(edges[$urandom_range(0, 7)] + int'($urandom_range(0, 2)) - 1);
                default: b.imm = $urandom & 32'hFFFFF000;
            endcase
            b.has_exp = 1'b0; b.exp_ok = 1'b0; b.exp_data = '0;
            if (!legal_only || ref_ok(b)) return b;
        end
        b.fmt = 3'd0;
        return b;
    endfunction

    task automatic drive(input beat_t b);
        fmt = b.fmt; opcode = b.op; rd = b.rd; rs1 = b.rs1; rs2 = b.rs2;
        funct3 = b.f3; funct7 = b.f7; imm32 = b.imm;
    endtask

    // Runs every beat in runq as one load run and checks handshake, writes,
    // done timing and the error summary against the model.
    task automatic do_run(input logic [ADDR_W-1:0] base, input int gap_pct, input bit poke_start);
        int                cnt, s_cyc, last, errs, k;
        logic [ADDR_W-1:0] a;
        bit                ok;
        logic [31:0]       d;
        cnt = runq.size();
        @(negedge clk);
        start = 1'b1; base_addr = base; count = ADDR_W'(cnt); s_cyc = cyc;
        @(negedge clk);
        start = 1'b0; base_addr = ADDR_W'($urandom); count = ADDR_W'($urandom);
        a = base; errs = 0; last = s_cyc;
        for (int i = 0; i < cnt; i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                chk("in_ready_gap", 32'(in_ready), 32'd1);
                @(negedge clk);
            end
            drive(runq[i]);
            in_valid = 1'b1;
            if (poke_start && i == cnt / 2) begin
                start = 1'b1; base_addr = ~base; count = 1;
            end
            chk("in_ready_beat", 32'(in_ready), 32'd1);
            ok = runq[i].has_exp ? runq[i].exp_ok : ref_ok(runq[i]);
            d  = runq[i].has_exp ? runq[i].exp_data : ref_word(runq[i]);
            if (ok) begin
                expq.push_back('{addr: a, data: d, cyc: cyc + 1});
                a = a + 1'b1;
            end else begin
                errs = (errs < 255) ? errs + 1 : 255;
            end
            last = cyc;
            @(negedge clk);
            start = 1'b0;
        end
        in_valid = 1'b0;
        chk("in_ready_after", 32'(in_ready), 32'd0);
        chk("busy_run", 32'(busy), 32'd1);
        k = 0;
        while (!done && k < 10) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL done_timeout: done not seen within 10 cycles");
        end else begin
            chk("done_cycle", 32'(cyc), 32'(last + 2));
            chk("busy_done", 32'(busy), 32'd1);
            chk("err", 32'(err), 32'(errs > 0));
            chk("err_cnt", 32'(err_cnt), 32'(errs));
        end
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("writes_left", 32'(expq.size()), 32'd0);
        expq.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, "_wr_data"}, wr_data, 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t b;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; base_addr = '0; count = '0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 32'h0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_zero("reset");

        tbl.push_back(mk(1, 'h13, 1, 0, 0, 0, 0, 5,        1, 32'h00500093));
        tbl.push_back(mk(2, 'h23, 0, 1, 2, 2, 0, 8,        1, 32'h0020A423));
        tbl.push_back(mk(3, 'h63, 0, 0, 0, 0, 0, -4,       1, 32'hFE000EE3));
        tbl.push_back(mk(5, 'h6F, 1, 0, 0, 0, 0, 2048,     1, 32'h001000EF));
        tbl.push_back(mk(0, 'h33, 3, 1, 2, 0, 'h20, 0,     1, 32'h402081B3));
        tbl.push_back(mk(4, 'h37, 5, 0, 0, 0, 0, 'h12345000, 1, 32'h123452B7));
        tbl.push_back(mk(4, 'h37, 5, 0, 0, 0, 0, 'h12345001, 0, 32'h0));
        tbl.push_back(mk(1, 'h13, 1, 0, 0, 0, 0, 2047,     1, 32'h7FF00093));
        tbl.push_back(mk(1, 'h13, 1, 0, 0, 0, 0, -2048,    1, 32'h80000093));
        tbl.push_back(mk(1, 'h13, 1, 0, 0, 0, 0, 2048,     0, 32'h0));
        tbl.push_back(mk(1, 'h13, 1, 0, 0, 0, 0, -2049,    0, 32'h0));
        tbl.push_back(mk(2, 'h23, 0, 1, 2, 2, 0, -2049,    0, 32'h0));
        tbl.push_back(mk(3, 'h63, 0, 0, 0, 0, 0, 4094,     1, 32'h7E000FE3));
        tbl.push_back(mk(3, 'h63, 0, 0, 0, 0, 0, -4096,    1, 32'h80000063));
        tbl.push_back(mk(3, 'h63, 0, 0, 0, 0, 0, 4096,     0, 32'h0));
        tbl.push_back(mk(3, 'h63, 0, 0, 0, 0, 0, 3,        0, 32'h0));
        tbl.push_back(mk(5, 'h6F, 0, 0, 0, 0, 0, 1048574,  1, 32'h7FFFF06F));
        tbl.push_back(mk(5, 'h6F, 0, 0, 0, 0, 0, -1048576, 1, 32'h8000006F));
        tbl.push_back(mk(5, 'h6F, 0, 0, 0, 0, 0, 1048576,  0, 32'h0));
        tbl.push_back(mk(6, 'h13, 1, 0, 0, 0, 0, 0,        0, 32'h0));
        tbl.push_back(mk(7, 'h13, 1, 0, 0, 0, 0, 0,        0, 32'h0));
        for (int i = 0; i < tbl.size(); i++) begin
            runq.delete();
            runq.push_back(tbl[i]);
            do_run(14'h10, 0, 1'b0);
        end

        // count 3 with an out-of-range middle beat
        runq.delete();
        runq.push_back(mk(1, 'h13, 1, 0, 0, 0, 0, 1,    1, 32'h00100093));
        runq.push_back(mk(1, 'h13, 1, 0, 0, 0, 0, 2048, 0, 32'h0));
        runq.push_back(mk(1, 'h13, 2, 0, 0, 0, 0, 2,    1, 32'h00200113));
        do_run(14'h40, 0, 1'b0);

        runq.delete();
        do_run(14'h55, 0, 1'b0);

        runq.delete();
        for (int i = 0; i < 16; i++) runq.push_back(rnd_beat(1'b1));
        do_run(14'h100, 0, 1'b0);

        runq.delete();
        for (int i = 0; i < 5; i++) runq.push_back(rnd_beat(1'b1));
        do_run(14'h3FFE, 0, 1'b0);

        runq.delete();
        for (int i = 0; i < 10; i++) runq.push_back(rnd_beat(1'b0));
        do_run(14'h200, 20, 1'b1);

        runq.delete();
        for (int i = 0; i < 260; i++) runq.push_back(mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        do_run(14'h300, 0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            runq.delete();
            for (int i = 0; i < int'($urandom_range(1, 24)); i++) runq.push_back(rnd_beat(1'b0));
            do_run(ADDR_W'($urandom), 30, 1'b0);
        end

        // reset mid-run after two of five beats, with a third beat pending
        @(negedge clk);
        start = 1'b1; base_addr = 14'h20; count = 14'd5;
        @(negedge clk);
        start = 1'b0;
        drive(mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        in_valid = 1'b1;
        @(negedge clk);
        b = mk(1, 'h13, 1, 0, 0, 0, 0, 5, 1, 32'h00500093);
        drive(b);
        expq.push_back('{addr: 14'h20, data: b.exp_data, cyc: cyc + 1});
        @(negedge clk);
        drive(mk(1, 'h13, 3, 0, 0, 0, 0, 7, 1, 32'h0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        chk_zero("midrst");
        chk("midrst_writes_left", 32'(expq.size()), 32'd0);
        expq.delete();

        runq.delete();
        runq.push_back(mk(1, 'h13, 1, 0, 0, 0, 0, 5, 1, 32'h00500093));
        do_run(14'h10, 0, 1'b0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
